// File: rtl/retire_trace_buffer_pkg.sv
// retire_trace_buffer_pkg: shared core types plus the retire-trace record format.
package retire_trace_buffer_pkg;

    localparam int XLEN         = 32;
    localparam int TRACE_DROP_W = 16;

    typedef enum logic [3:0] {
        OP_ADDI, OP_ADD, OP_LW, OP_SW, OP_SH, OP_SB, OP_BEQ, OP_JAL
    } operation_e;

    typedef enum logic [2:0] {
        TR_NONE, TR_REG, TR_LOAD, TR_ST_W, TR_ST_H, TR_ST_B, TR_DROP
    } trace_kind_e;

    typedef struct packed {
        logic [31:0]     seq;
        trace_kind_e     kind;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
        logic [XLEN-1:0] addr;
    } trace_rec_t;

endpackage

// File: rtl/retire_trace_buffer_fifo.sv
// trace_fifo: generic synchronous FIFO; pointers carry one extra wrap bit so full and empty differ.
module trace_fifo #(
    parameter type T     = logic,
    parameter int  DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     push_i,
    input  T                         wdata_i,
    input  logic                     pop_i,
    output T                         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int AW = $clog2(DEPTH);

    T           mem_q [DEPTH];
    logic [AW:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic        do_push, do_pop;

    always_comb begin
        full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
        empty_o = wptr_q == rptr_q;
        level_o = wptr_q - rptr_q;
        do_push = push_i && (!full_o || pop_i);
        do_pop  = pop_i && !empty_o;
        wptr_d  = do_push ? wptr_q + 1'b1 : wptr_q;
        rptr_d  = do_pop ? rptr_q + 1'b1 : rptr_q;
        // An empty FIFO presents an all-zero record rather than stale storage
        rdata_o = empty_o ? '0 : mem_q[rptr_q[AW-1:0]];
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/retire_trace_buffer.sv
// retire_trace_buffer: classifies retired instructions into trace records and buffers them for a log sink.
module retire_trace_buffer
    import retire_trace_buffer_pkg::*;
#(
    parameter int XLEN          = retire_trace_buffer_pkg::XLEN,
    parameter int DEPTH         = 16,
    parameter int STALL_ON_FULL = 0,
    parameter int SKIP_PC0      = 1
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     enable_i,
    input  logic                     clear_i,
    input  logic                     commit_i,
    input  logic [XLEN-1:0]          pc_i,
    input  logic [XLEN-1:0]          instr_i,
    input  logic [4:0]               rd_i,
    input  logic [XLEN-1:0]          rd_data_i,
    input  logic                     rf_we_i,
    input  logic                     mem_re_i,
    input  logic                     mem_we_i,
    input  logic [XLEN-1:0]          mem_raddr_i,
    input  logic [XLEN-1:0]          mem_waddr_i,
    input  logic [XLEN-1:0]          mem_wdata_i,
    input  operation_e               op_i,
    output logic                     stall_o,
    output logic                     trace_valid_o,
    input  logic                     trace_ready_i,
    output trace_rec_t               trace_rec_o,
    output logic                     overflow_o,
    output logic [TRACE_DROP_W-1:0]  drop_cnt_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    trace_kind_e              kind;
    logic [4:0]               rd;
    logic [XLEN-1:0]          data, addr;
    logic                     qual, pop, accept, drop, full, empty;
    logic [31:0]              seq_q, seq_d;
    logic                     overflow_d;
    logic [TRACE_DROP_W-1:0]  drop_cnt_d;
    trace_rec_t               rec;

    always_comb begin
        kind = TR_NONE;
        rd   = '0;
        data = '0;
        addr = '0;
        if (mem_we_i) begin
            addr = mem_waddr_i;
            kind = op_i == OP_SW ? TR_ST_W : op_i == OP_SH ? TR_ST_H : op_i == OP_SB ? TR_ST_B : TR_DROP;
            data = op_i == OP_SW ? mem_wdata_i :
                   op_i == OP_SH ? {{(XLEN-16){1'b0}}, mem_wdata_i[15:0]} :
                                   {{(XLEN-8){1'b0}}, mem_wdata_i[7:0]};
        end else if (mem_re_i) begin
            kind = rd_i != 5'd0 ? TR_LOAD : TR_DROP;
            rd   = rd_i;
            data = rd_data_i;
            addr = mem_raddr_i;
        end else if (rd_i != 5'd0 && rf_we_i) begin
            kind = TR_REG;
            rd   = rd_i;
            data = rd_data_i;
        end
    end

    always_comb begin
        qual    = commit_i && enable_i && !(SKIP_PC0 != 0 && pc_i == '0) && kind != TR_DROP;
        pop     = trace_valid_o && trace_ready_i;
        // Stall mode has no pop lookahead: the core is already holding while full
        accept  = qual && (STALL_ON_FULL != 0 ? !full : (!full || pop));
        drop    = qual && !accept && STALL_ON_FULL == 0;
        stall_o = STALL_ON_FULL != 0 && full;
        seq_d   = (accept || drop) ? seq_q + 32'd1 : seq_q;
        overflow_d = clear_i ? 1'b0 : (overflow_o || drop);
        drop_cnt_d = clear_i ? '0 : (drop && drop_cnt_o != '1) ? drop_cnt_o + 1'b1 : drop_cnt_o;
        trace_valid_o = !empty;
        rec = '{seq: seq_q, kind: kind, pc: pc_i, instr: instr_i, rd: rd, data: data, addr: addr};
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            seq_q      <= '0;
            overflow_o <= 1'b0;
            drop_cnt_o <= '0;
        end else begin
            seq_q      <= seq_d;
            overflow_o <= overflow_d;
            drop_cnt_o <= drop_cnt_d;
        end
    end

    trace_fifo #(.T(trace_rec_t), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .push_i  (accept),
        .wdata_i (rec),
        .pop_i   (pop),
        .rdata_o (trace_rec_o),
        .full_o  (full),
        .empty_o (empty),
        .level_o (level_o)
    );

endmodule
